// File: rtl/gmii_rx_sanitizer_pkg.sv
// Shared constants, FSM encoding and helpers for the GMII receive sanitizer.
package gmii_rx_sanitizer_pkg;

  localparam logic [7:0] GMII_PREAMBLE = 8'h55;
  localparam logic [7:0] GMII_SFD      = 8'hD5;

  localparam int unsigned LEN_W       = 16;
  localparam int unsigned IFG_W       = 8;
  localparam int unsigned DLY_DEPTH   = 8;
  localparam int unsigned DLY_W       = 10;
  localparam int unsigned PRE_MAX_IDX = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_PASS,
    ST_TRUNC,
    ST_DROP
  } rx_state_e;

  typedef struct packed {
    logic       dv;
    logic       er;
    logic [7:0] rxd;
  } gmii_beat_t;

  function automatic logic [LEN_W-1:0] sat_inc_len(input logic [LEN_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/gmii_delay_line.sv
// Fixed-depth shift register for GMII beats; reset flushes every stage at once.
module gmii_delay_line
  import gmii_rx_sanitizer_pkg::*;
#(
  parameter int unsigned DEPTH = DLY_DEPTH,
  parameter int unsigned WIDTH = DLY_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/gmii_rx_sanitizer.sv
// GMII receive sanitizer: judges each frame on the input side (preamble/SFD, IFG, length)
// and gates a 9-cycle delayed copy of the stream; keeps saturating per-cause statistics.
module gmii_rx_sanitizer
  import gmii_rx_sanitizer_pkg::*;
#(
  parameter int unsigned MIN_IFG = 12,
  parameter int unsigned MAX_LEN = 1530,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_gmii_dv,
  input  logic [7:0]       iv_gmii_rxd,
  input  logic             i_gmii_er,
  output logic             o_gmii_dv,
  output logic [7:0]       ov_gmii_rxd,
  output logic             o_gmii_er,
  input  logic             i_cnt_clr,
  output logic [CNT_W-1:0] ov_good_cnt,
  output logic [CNT_W-1:0] ov_pre_err_cnt,
  output logic [CNT_W-1:0] ov_ifg_err_cnt,
  output logic [CNT_W-1:0] ov_trunc_cnt,
  output logic             o_drop_pulse
);

  localparam logic [IFG_W-1:0] MIN_IFG_C = IFG_W'(MIN_IFG);
  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] TRUNC_IDX = LEN_W'(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] PRE_LAST  = LEN_W'(PRE_MAX_IDX);

  rx_state_e        state_q, state_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [IFG_W-1:0] ifg_q, ifg_d;
  logic             dv_prev_q;
  logic             keep_q, keep_d;
  logic             pulse_q, pulse_d;
  logic             drop_pre, drop_ifg, good_inc, trunc_inc;

  logic [DLY_W-1:0] dly_in, dly_out;
  gmii_beat_t       dly_beat, out_q, out_d;
  logic [LEN_W-1:0] oidx_q, oidx_d;

  logic [CNT_W-1:0] good_q, pre_q, ifg_err_q, trunc_q;

  // dv_prev_q resets high so a frame already in flight at reset release is not seen as a rising edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      ifg_q     <= MIN_IFG_C;
      dv_prev_q <= 1'b1;
      keep_q    <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ifg_q     <= ifg_d;
      dv_prev_q <= i_gmii_dv;
      keep_q    <= keep_d;
      pulse_q   <= pulse_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    drop_pre = 1'b0;
    drop_ifg = 1'b0;
    if (i_gmii_dv && !dv_prev_q) begin
      ifg_d = '0;
    end else if (!i_gmii_dv && (ifg_q != '1)) begin
      ifg_d = ifg_q + 1'b1;
    end else begin
      ifg_d = ifg_q;
    end
    unique case (state_q)
      // The rising-edge byte is judged here as preamble index 1
      ST_IDLE: begin
        if (i_gmii_dv) begin
          if (dv_prev_q) begin
            state_d = ST_DROP;
          end else if (ifg_q < MIN_IFG_C) begin
            state_d  = ST_DROP;
            drop_ifg = 1'b1;
          end else if (iv_gmii_rxd == GMII_PREAMBLE) begin
            state_d = ST_PRE;
            idx_d   = LEN_W'(2);
          end else begin
            state_d  = ST_DROP;
            drop_pre = 1'b1;
          end
        end
      end
      ST_PRE: begin
        if (i_gmii_dv && (iv_gmii_rxd == GMII_PREAMBLE) && (idx_q <= PRE_LAST)) begin
          idx_d = sat_inc_len(idx_q);
        end else if (i_gmii_dv && (iv_gmii_rxd == GMII_SFD)) begin
          state_d = ST_PASS;
          idx_d   = sat_inc_len(idx_q);
        end else begin
          state_d  = ST_DROP;
          drop_pre = 1'b1;
        end
      end
      ST_PASS: begin
        if (!i_gmii_dv) begin
          state_d = ST_IDLE;
        end else begin
          idx_d = sat_inc_len(idx_q);
          if (idx_q == TRUNC_IDX) begin
            state_d = ST_TRUNC;
          end
        end
      end
      ST_TRUNC, ST_DROP: begin
        if (!i_gmii_dv) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    good_inc  = (state_q == ST_PASS) && !i_gmii_dv;
    trunc_inc = (state_q == ST_TRUNC) && !i_gmii_dv;
    pulse_d   = drop_pre || drop_ifg || ((state_q == ST_PASS) && (state_d == ST_TRUNC));
    keep_d    = keep_q;
    if ((state_q == ST_IDLE) && i_gmii_dv) begin
      keep_d = 1'b0;
    end else if ((state_q == ST_PRE) && (state_d == ST_PASS)) begin
      keep_d = 1'b1;
    end
  end

  assign dly_in = {i_gmii_dv, i_gmii_er, iv_gmii_rxd};

  gmii_delay_line #(
    .DEPTH(DLY_DEPTH),
    .WIDTH(DLY_W)
  ) u_delay (
    .clk_i (i_clk),
    .rst_ni(i_rst_n),
    .d_i   (dly_in),
    .q_o   (dly_out)
  );

  assign dly_beat = gmii_beat_t'(dly_out);

  // keep_q is settled by the time a frame's first byte reaches the end of the delay line
  always_comb begin
    out_d  = '0;
    oidx_d = dly_beat.dv ? sat_inc_len(oidx_q) : '0;
    if (dly_beat.dv && keep_q) begin
      if (oidx_d <= MAX_LEN_C) begin
        out_d = dly_beat;
      end else if (oidx_d == TRUNC_IDX) begin
        out_d = '{dv: 1'b1, er: 1'b1, rxd: dly_beat.rxd};
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_q  <= '0;
      oidx_q <= '0;
    end else begin
      out_q  <= out_d;
      oidx_q <= oidx_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      good_q    <= '0;
      pre_q     <= '0;
      ifg_err_q <= '0;
      trunc_q   <= '0;
    end else if (i_cnt_clr) begin
      good_q    <= '0;
      pre_q     <= '0;
      ifg_err_q <= '0;
      trunc_q   <= '0;
    end else begin
      if (good_inc && (good_q != '1)) good_q <= good_q + 1'b1;
      if (drop_pre && (pre_q != '1)) pre_q <= pre_q + 1'b1;
      if (drop_ifg && (ifg_err_q != '1)) ifg_err_q <= ifg_err_q + 1'b1;
      if (trunc_inc && (trunc_q != '1)) trunc_q <= trunc_q + 1'b1;
    end
  end

  assign o_gmii_dv      = out_q.dv;
  assign o_gmii_er      = out_q.er;
  assign ov_gmii_rxd    = out_q.rxd;
  assign o_drop_pulse   = pulse_q;
  assign ov_good_cnt    = good_q;
  assign ov_pre_err_cnt = pre_q;
  assign ov_ifg_err_cnt = ifg_err_q;
  assign ov_trunc_cnt   = trunc_q;

endmodule

// File: tb/tb_gmii_rx_sanitizer.sv
// Directed bench for gmii_rx_sanitizer: frames built in a table, output captured and compared.
module tb_gmii_rx_sanitizer;

  localparam int MAX_LEN = 1530;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             dv, er;
  logic [7:0]       rxd;
  logic             cnt_clr;
  logic             o_dv, o_er, o_pulse;
  logic [7:0]       o_rxd;
  logic [CNT_W-1:0] good_cnt, pre_cnt, ifg_cnt, trunc_cnt;

  gmii_rx_sanitizer #(
    .MIN_IFG(12),
    .MAX_LEN(MAX_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_gmii_dv     (dv),
    .iv_gmii_rxd   (rxd),
    .i_gmii_er     (er),
    .o_gmii_dv     (o_dv),
    .ov_gmii_rxd   (o_rxd),
    .o_gmii_er     (o_er),
    .i_cnt_clr     (cnt_clr),
    .ov_good_cnt   (good_cnt),
    .ov_pre_err_cnt(pre_cnt),
    .ov_ifg_err_cnt(ifg_cnt),
    .ov_trunc_cnt  (trunc_cnt),
    .o_drop_pulse  (o_pulse)
  );

  always #4 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int first_in_cyc = 0;
  int first_out_cyc = 0;
  int cap_n = 0;
  int pulses = 0;
  int leak = 0;
  logic [8:0] cap [0:3199];
  logic [7:0] tx [0:1599];
  logic       txer [0:1599];
  int tx_len = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (o_dv) begin
      if (cap_n == 0) first_out_cyc = cyc;
      if (cap_n < 3200) cap[cap_n] = {o_er, o_rxd};
      cap_n++;
    end else if (o_er || (o_rxd != 8'h00)) begin
      leak++;
    end
    if (o_pulse) pulses++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_bytes(input int from, input int to);
    for (int i = from; i < to; i++) begin
      if (i == 0) first_in_cyc = cyc;
      dv  = 1'b1;
      rxd = tx[i];
      er  = txer[i];
      tick();
    end
  endtask

  task automatic end_frame();
    dv  = 1'b0;
    er  = 1'b0;
    rxd = 8'h00;
  endtask

  task automatic send_frame();
    send_bytes(0, tx_len);
    end_frame();
  endtask

  // sfd_idx is the 1-based position of the SFD; everything before it is preamble
  task automatic build_good(input int len, input int sfd_idx);
    for (int i = 0; i < len; i++) begin
      txer[i] = 1'b0;
      if (i < sfd_idx - 1) tx[i] = 8'h55;
      else if (i == sfd_idx - 1) tx[i] = 8'hD5;
      else tx[i] = 8'((i * 7 + 3) & 8'hFF);
    end
    tx_len = len;
  endtask

  task automatic clear_cap();
    cap_n  = 0;
    pulses = 0;
  endtask

  task automatic check_stream(input string tag, input int flen_in, input int nfr);
    int flen, bad, idx;
    logic [8:0] exp;
    flen = (flen_in > MAX_LEN) ? MAX_LEN + 1 : flen_in;
    bad  = 0;
    for (int k = 0; k < cap_n && k < 3200; k++) begin
      idx = k % flen;
      exp = {txer[idx], tx[idx]};
      if (idx == MAX_LEN) exp[8] = 1'b1;
      if (cap[k] !== exp) bad++;
    end
    check_eq({tag, " len"}, cap_n, flen * nfr);
    check_eq({tag, " data"}, bad, 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    dv      = 1'b0;
    er      = 1'b0;
    rxd     = 8'h00;
    cnt_clr = 1'b0;
    idle(3);
    check_eq("rst dv", o_dv, 0);
    check_eq("rst er", o_er, 0);
    check_eq("rst rxd", o_rxd, 0);
    check_eq("rst pulse", o_pulse, 0);
    check_eq("rst good", good_cnt, 0);
    check_eq("rst pre", pre_cnt, 0);
    check_eq("rst ifg", ifg_cnt, 0);
    check_eq("rst trunc", trunc_cnt, 0);
    rst_n = 1'b1;
    idle(12);

    // Good 72-byte frame with an error flag on one payload byte
    build_good(72, 8);
    txer[40] = 1'b1;
    clear_cap();
    send_frame();
    idle(20);
    check_stream("good72", 72, 1);
    check_eq("good72 latency", first_out_cyc - first_in_cyc, 9);
    check_eq("good72 cnt", good_cnt, 1);
    check_eq("good72 pulses", pulses, 0);

    // Bad preamble: 3x55 then 54
    build_good(24, 8);
    tx[3] = 8'h54;
    clear_cap();
    send_frame();
    idle(20);
    check_eq("badpre len", cap_n, 0);
    check_eq("badpre cnt", pre_cnt, 1);
    check_eq("badpre pulses", pulses, 1);

    // SFD as the very first byte
    build_good(20, 1);
    clear_cap();
    send_frame();
    idle(20);
    check_eq("sfd1 len", cap_n, 0);
    check_eq("sfd1 cnt", pre_cnt, 2);

    // Eight preamble bytes then SFD at index 9
    build_good(20, 9);
    clear_cap();
    send_frame();
    idle(20);
    check_eq("sfd9 len", cap_n, 0);
    check_eq("sfd9 cnt", pre_cnt, 3);

    // Shortest legal preamble: SFD at index 2
    build_good(12, 2);
    clear_cap();
    send_frame();
    idle(20);
    check_stream("sfd2", 12, 1);
    check_eq("sfd2 cnt", good_cnt, 2);

    // Short IFG: A, 8 idle, B dropped, 12 idle, C passes
    build_good(72, 8);
    clear_cap();
    send_frame();
    idle(8);
    send_frame();
    idle(12);
    send_frame();
    idle(20);
    check_stream("ifg", 72, 2);
    check_eq("ifg err cnt", ifg_cnt, 1);
    check_eq("ifg good cnt", good_cnt, 4);
    check_eq("ifg pulses", pulses, 1);

    // Oversize 1600 bytes: byte 1531 carries er, rest suppressed
    build_good(1600, 8);
    clear_cap();
    send_frame();
    idle(20);
    check_stream("over1600", 1600, 1);
    check_eq("over trunc cnt", trunc_cnt, 1);
    check_eq("over good cnt", good_cnt, 4);
    check_eq("over pulses", pulses, 1);

    // Exactly MAX_LEN passes intact
    build_good(1530, 8);
    clear_cap();
    send_frame();
    idle(20);
    check_stream("max1530", 1530, 1);
    check_eq("max good cnt", good_cnt, 5);
    check_eq("max pulses", pulses, 0);

    // Mid-frame reset at byte 30, released while dv is still high
    build_good(72, 8);
    send_bytes(0, 29);
    rst_n = 1'b0;
    clear_cap();
    send_bytes(29, 31);
    check_eq("midrst dv", o_dv, 0);
    rst_n = 1'b1;
    send_bytes(31, 72);
    end_frame();
    idle(12);
    check_eq("midrst len", cap_n, 0);
    check_eq("midrst good", good_cnt, 0);
    check_eq("midrst pre", pre_cnt, 0);
    check_eq("midrst ifg", ifg_cnt, 0);
    check_eq("midrst trunc", trunc_cnt, 0);
    clear_cap();
    send_frame();
    idle(20);
    check_stream("postrst", 72, 1);
    check_eq("postrst good", good_cnt, 1);

    // Clear, then saturate the good counter
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check_eq("clr good", good_cnt, 0);
    build_good(12, 8);
    for (int f = 0; f < 16; f++) begin
      send_frame();
      idle(12);
    end
    check_eq("sat good", good_cnt, 15);

    // Clear in the same cycle as a good-frame increment
    send_frame();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    idle(2);
    check_eq("clr wins", good_cnt, 0);

    idle(20);
    check_eq("no leak", leak, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
